bundle_beat_packer: RTL and testbench



---
 rtl/bundle_pack_pkg.sv | 56 +++++
 rtl/bundle_flatten.sv | 49 ++++
 rtl/bundle_beat_packer.sv | 174 +++++++++++++++++
 tb/tb_bundle_beat_packer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bundle_pack_pkg.sv
// bundle_pack_pkg
//   Shared definitions for the bundle packing family.
//   - calc_rec_w / calc_tot_w / calc_num_beats / calc_idx_w: derived widths.
//   - pack_state_e: packer FSM states.
//   - field_offset: bit offset of each record field inside one record,
//     LSB to MSB: b, then for each bar entry j: d[j], c[j], then a.
//     An unpacker uses the same function so both sides agree on layout.
package bundle_pack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } pack_state_e;

  typedef enum logic [1:0] {
    FLD_B = 2'd0,
    FLD_D = 2'd1,
    FLD_C = 2'd2,
    FLD_A = 2'd3
  } field_kind_e;

  function automatic int calc_rec_w(input int a_w, input int bar_depth,
                                    input int c_w, input int d_w, input int b_w);
    return a_w + bar_depth * (c_w + d_w) + b_w;
  endfunction

  function automatic int calc_tot_w(input int num_elem, input int rec_w);
    return num_elem * rec_w;
  endfunction

  function automatic int calc_num_beats(input int tot_w, input int beat_w);
    return (tot_w + beat_w - 1) / beat_w;
  endfunction

  // Beat index width; never narrower than one bit.
  function automatic int calc_idx_w(input int num_beats);
    return (num_beats > 1) ? $clog2(num_beats) : 1;
  endfunction

  // Offset of a field within a record. j selects the bar entry for FLD_D/FLD_C.
  function automatic int field_offset(input field_kind_e kind, input int j,
                                      input int bar_depth, input int c_w,
                                      input int d_w, input int b_w);
    int pair_w;
    int off;
    pair_w = c_w + d_w;
    case (kind)
      FLD_B:   off = 0;
      FLD_D:   off = b_w + j * pair_w;
      FLD_C:   off = b_w + j * pair_w + d_w;
      default: off = b_w + bar_depth * pair_w;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/bundle_flatten.sv
// bundle_flatten
//   Purely combinational: maps a vector of NUM_ELEM records onto one flat
//   word. Element e occupies flat[e*REC_W +: REC_W]; fields inside a record
//   are placed by bundle_pack_pkg::field_offset.
// Ports:
//   in_a      NUM_ELEM*A_W             field a per element
//   in_bar_c  NUM_ELEM*BAR_DEPTH*C_W   c of bar entry (e*BAR_DEPTH+j)
//   in_bar_d  NUM_ELEM*BAR_DEPTH*D_W   d of bar entry (e*BAR_DEPTH+j)
//   in_b      NUM_ELEM*B_W             field b per element
//   flat      TOT_W                    packed record vector
module bundle_flatten
  import bundle_pack_pkg::*;
#(
  parameter int NUM_ELEM  = 2,
  parameter int BAR_DEPTH = 2,
  parameter int A_W       = 10,
  parameter int C_W       = 1,
  parameter int D_W       = 20,
  parameter int B_W       = 11,
  localparam int REC_W    = calc_rec_w(A_W, BAR_DEPTH, C_W, D_W, B_W),
  localparam int TOT_W    = calc_tot_w(NUM_ELEM, REC_W)
) (
  input  logic [NUM_ELEM*A_W-1:0]           in_a,
  input  logic [NUM_ELEM*BAR_DEPTH*C_W-1:0] in_bar_c,
  input  logic [NUM_ELEM*BAR_DEPTH*D_W-1:0] in_bar_d,
  input  logic [NUM_ELEM*B_W-1:0]           in_b,
  output logic [TOT_W-1:0]                  flat
);

  localparam int B_OFF = field_offset(FLD_B, 0, BAR_DEPTH, C_W, D_W, B_W);
  localparam int A_OFF = field_offset(FLD_A, 0, BAR_DEPTH, C_W, D_W, B_W);

  for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
    localparam int BASE = gi * REC_W;

    assign flat[BASE + B_OFF +: B_W] = in_b[gi*B_W +: B_W];
    assign flat[BASE + A_OFF +: A_W] = in_a[gi*A_W +: A_W];

    for (genvar gj = 0; gj < BAR_DEPTH; gj++) begin : g_bar
      localparam int IDX   = gi * BAR_DEPTH + gj;
      localparam int D_OFF = field_offset(FLD_D, gj, BAR_DEPTH, C_W, D_W, B_W);
      localparam int C_OFF = field_offset(FLD_C, gj, BAR_DEPTH, C_W, D_W, B_W);

      assign flat[BASE + D_OFF +: D_W] = in_bar_d[IDX*D_W +: D_W];
      assign flat[BASE + C_OFF +: C_W] = in_bar_c[IDX*C_W +: C_W];
    end
  end

endmodule

// File: rtl/bundle_beat_packer.sv
// bundle_beat_packer
//   Captures a vector of NUM_ELEM records on the input handshake, flattens it
//   and streams the flat word out as NUM_BEATS beats of BEAT_W bits.
//   Bits at TOT_W and above in the last beat are zero.
// Ports:
//   clock, reset_n                   clock, asynchronous active-low reset
//   in_valid / in_ready              input vector handshake
//   in_a, in_bar_c, in_bar_d, in_b   record fields (see bundle_flatten)
//   out_valid / out_ready            beat handshake
//   out_data                         current beat
//   out_idx                          beat position in the flat word
//   out_last                         final beat of the vector
module bundle_beat_packer
  import bundle_pack_pkg::*;
#(
  parameter int NUM_ELEM  = 2,
  parameter int BAR_DEPTH = 2,
  parameter int A_W       = 10,
  parameter int C_W       = 1,
  parameter int D_W       = 20,
  parameter int B_W       = 11,
  parameter int BEAT_W    = 42,
  parameter int MSB_FIRST = 0,
  localparam int REC_W     = calc_rec_w(A_W, BAR_DEPTH, C_W, D_W, B_W),
  localparam int TOT_W     = calc_tot_w(NUM_ELEM, REC_W),
  localparam int NUM_BEATS = calc_num_beats(TOT_W, BEAT_W),
  localparam int IDX_W     = calc_idx_w(NUM_BEATS)
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_ELEM*A_W-1:0]           in_a,
  input  logic [NUM_ELEM*BAR_DEPTH*C_W-1:0] in_bar_c,
  input  logic [NUM_ELEM*BAR_DEPTH*D_W-1:0] in_bar_d,
  input  logic [NUM_ELEM*B_W-1:0]           in_b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BEAT_W-1:0]                 out_data,
  output logic [IDX_W-1:0]                  out_idx,
  output logic                              out_last
);

  // The beat arrays are sized to the full index range so every counter value
  // selects a defined (zero) slot, even when NUM_BEATS is not a power of two.
  localparam int SLOTS = 1 << IDX_W;
  localparam int PAD_W = SLOTS * BEAT_W;

  localparam logic [IDX_W-1:0] START_IDX = (MSB_FIRST != 0) ? IDX_W'(NUM_BEATS - 1) : '0;
  localparam logic [IDX_W-1:0] TERM_IDX  = (MSB_FIRST != 0) ? '0 : IDX_W'(NUM_BEATS - 1);

  logic [TOT_W-1:0]  flat;
  logic [PAD_W-1:0]  flat_pad;
  logic [BEAT_W-1:0] in_beat   [SLOTS];
  logic [BEAT_W-1:0] hold_beat [SLOTS];

  pack_state_e       state_reg, state_next;
  logic [PAD_W-1:0]  hold_reg, hold_next;
  logic [IDX_W-1:0]  cnt_reg, cnt_next, cnt_step;
  logic [BEAT_W-1:0] data_reg, data_next;
  logic              last_reg, last_next;
  logic              capture;
  logic              advance;

  bundle_flatten #(
    .NUM_ELEM  (NUM_ELEM),
    .BAR_DEPTH (BAR_DEPTH),
    .A_W       (A_W),
    .C_W       (C_W),
    .D_W       (D_W),
    .B_W       (B_W)
  ) u_flatten (
    .in_a     (in_a),
    .in_bar_c (in_bar_c),
    .in_bar_d (in_bar_d),
    .in_b     (in_b),
    .flat     (flat)
  );

  always_comb begin
    flat_pad = '0;
    flat_pad[TOT_W-1:0] = flat;
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_beat
    assign in_beat[gi]   = flat_pad[gi*BEAT_W +: BEAT_W];
    assign hold_beat[gi] = hold_reg[gi*BEAT_W +: BEAT_W];
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    advance    = 1'b0;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!last_reg) begin
            advance = 1'b1;
          end else begin
            // Last beat leaves this cycle, so a new vector can be taken
            // in the same cycle without a bubble.
            in_ready = 1'b1;
            if (in_valid) begin
              capture = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state_reg == SEND);

  // ------------------------------------------------------------ datapath
  assign cnt_step = (MSB_FIRST != 0) ? (cnt_reg - IDX_W'(1)) : (cnt_reg + IDX_W'(1));

  // The first beat is taken straight from the live flat word so it is
  // presented one cycle after the handshake; later beats come from hold_reg.
  always_comb begin
    hold_next = hold_reg;
    cnt_next  = cnt_reg;
    data_next = data_reg;
    last_next = last_reg;
    if (capture) begin
      hold_next = flat_pad;
      cnt_next  = START_IDX;
      data_next = in_beat[START_IDX];
      last_next = (START_IDX == TERM_IDX);
    end else if (advance) begin
      cnt_next  = cnt_step;
      data_next = hold_beat[cnt_step];
      last_next = (cnt_step == TERM_IDX);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg <= '0;
      cnt_reg  <= '0;
      data_reg <= '0;
      last_reg <= 1'b0;
    end else begin
      hold_reg <= hold_next;
      cnt_reg  <= cnt_next;
      data_reg <= data_next;
      last_reg <= last_next;
    end
  end

  assign out_data = data_reg;
  assign out_idx  = cnt_reg;
  assign out_last = last_reg;

endmodule

// File: tb/tb_bundle_beat_packer.sv
// tb_bundle_beat_packer
//   Three packers share one clock: dut0 defaults (LSB beat first, 42-bit
//   beats), dut1 MSB beat first, dut2 with 32-bit beats. Each has its own
//   inputs. A reference model builds the flat word from record fields by
//   concatenation and queues the expected beats on every input handshake.
module tb_bundle_beat_packer;

  typedef struct {
    logic [63:0] data;
    int          idx;
    bit          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_ready_v;
  logic [2:0]  out_last_v;
  logic [19:0] in_a_v     [3];
  logic [3:0]  in_bar_c_v [3];
  logic [79:0] in_bar_d_v [3];
  logic [21:0] in_b_v     [3];
  logic [41:0] out_data0, out_data1;
  logic [31:0] out_data2;
  logic [1:0]  out_idx_v  [3];

  beat_t exp_q [3][$];
  int    n_vec  = 0;
  int    n_fail = 0;
  int    busy [3];
  bit [2:0] acc;

  bundle_beat_packer dut0 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_a(in_a_v[0]), .in_bar_c(in_bar_c_v[0]), .in_bar_d(in_bar_d_v[0]), .in_b(in_b_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_data(out_data0), .out_idx(out_idx_v[0]), .out_last(out_last_v[0])
  );

  bundle_beat_packer #(.MSB_FIRST(1)) dut1 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_a(in_a_v[1]), .in_bar_c(in_bar_c_v[1]), .in_bar_d(in_bar_d_v[1]), .in_b(in_b_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_data(out_data1), .out_idx(out_idx_v[1]), .out_last(out_last_v[1])
  );

  bundle_beat_packer #(.BEAT_W(32)) dut2 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_a(in_a_v[2]), .in_bar_c(in_bar_c_v[2]), .in_bar_d(in_bar_d_v[2]), .in_b(in_b_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_data(out_data2), .out_idx(out_idx_v[2]), .out_last(out_last_v[2])
  );

  function automatic logic [63:0] obs_data(input int i);
    case (i)
      0:       return 64'(out_data0);
      1:       return 64'(out_data1);
      default: return 64'(out_data2);
    endcase
  endfunction

  task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, i, obs, exp);
    end
  endtask

  // Record = {a, c[1], d[1], c[0], d[0], b}; element e sits at e*63.
  function automatic logic [127:0] model_flat(input logic [19:0] a, input logic [3:0] c,
                                              input logic [79:0] d, input logic [21:0] b);
    logic [127:0] f;
    logic [62:0]  rec;
    f = '0;
    for (int e = 0; e < 2; e++) begin
      rec = {a[e*10 +: 10], c[e*2+1], d[(e*2+1)*20 +: 20], c[e*2], d[(e*2)*20 +: 20], b[e*11 +: 11]};
      f = f | ({65'd0, rec} << (e*63));
    end
    return f;
  endfunction

  task automatic push_vec(input int i);
    logic [127:0] flat, sh;
    int w, nb, k;
    beat_t bt;
    flat = model_flat(in_a_v[i], in_bar_c_v[i], in_bar_d_v[i], in_b_v[i]);
    w  = (i == 2) ? 32 : 42;
    nb = (126 + w - 1) / w;
    for (int n = 0; n < nb; n++) begin
      k = (i == 1) ? (nb - 1 - n) : n;
      sh = flat >> (k * w);
      bt.data = sh[63:0] & ((64'd1 << w) - 64'd1);
      bt.idx  = k;
      bt.last = (n == nb - 1);
      exp_q[i].push_back(bt);
    end
  endtask

  task automatic rand_fields(input int i);
    in_a_v[i]     = 20'($urandom);
    in_bar_c_v[i] = 4'($urandom);
    in_bar_d_v[i] = {16'($urandom), $urandom, $urandom};
    in_b_v[i]     = 22'($urandom);
  endtask

  task automatic zero_fields();
    for (int i = 0; i < 3; i++) begin
      in_a_v[i] = '0; in_bar_c_v[i] = '0; in_bar_d_v[i] = '0; in_b_v[i] = '0;
    end
  endtask

  // One clock: check every DUT at the falling edge, then return 1 time unit
  // after the rising edge, where stimulus may change.
  task automatic step();
    beat_t f;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      acc[i] = 1'b0;
      if (out_valid_v[i]) busy[i]++;
      chk("out_valid", i, 64'(out_valid_v[i]), 64'(exp_q[i].size() != 0));
      if (exp_q[i].size() != 0) begin
        f = exp_q[i][0];
        chk("out_data", i, obs_data(i), f.data);
        chk("out_idx", i, 64'(out_idx_v[i]), 64'(f.idx));
        chk("out_last", i, 64'(out_last_v[i]), 64'(f.last));
        chk("in_ready", i, 64'(in_ready_v[i]), 64'(out_ready_v[i] & f.last));
        if (out_valid_v[i] && out_ready_v[i]) void'(exp_q[i].pop_front());
      end else begin
        chk("in_ready_idle", i, 64'(in_ready_v[i]), 64'd1);
      end
      if (in_valid_v[i] && in_ready_v[i]) begin
        push_vec(i);
        acc[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready_v = 3'b111;
    for (int c = 0; c < 50 && !done; c++) begin
      step();
      done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
    end
    chk("drain_done", 0, 64'(done), 64'd1);
  endtask

  task automatic run(input int n0, input int n1, input int n2, input bit rnd_ready, input int max_cyc);
    int left [3];
    bit done;
    left = '{n0, n1, n2};
    for (int i = 0; i < 3; i++) begin
      if (left[i] > 0) begin
        rand_fields(i);
        in_valid_v[i] = 1'b1;
      end else begin
        in_valid_v[i] = 1'b0;
      end
    end
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      for (int i = 0; i < 3; i++) out_ready_v[i] = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          left[i]--;
          if (left[i] > 0) rand_fields(i);
          else in_valid_v[i] = 1'b0;
        end
      end
      done = (left[0] == 0) && (left[1] == 0) && (left[2] == 0) &&
             (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
    end
    chk("run_done", 0, 64'(done), 64'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    busy        = '{0, 0, 0};
    zero_fields();

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", i, 64'(out_valid_v[i]), 64'd0);
      chk("rst_in_ready", i, 64'(in_ready_v[i]), 64'd1);
      chk("rst_out_data", i, obs_data(i), 64'd0);
      chk("rst_out_idx", i, 64'(out_idx_v[i]), 64'd0);
      chk("rst_out_last", i, 64'(out_last_v[i]), 64'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Element 0 b all ones, everything else zero.
    zero_fields();
    for (int i = 0; i < 3; i++) in_b_v[i] = 22'h7FF;
    in_valid_v  = 3'b111;
    out_ready_v = 3'b111;
    step();
    in_valid_v = '0;
    chk("t1_first_data", 0, 64'(out_data0), 64'h7FF);
    chk("t1_first_idx", 0, 64'(out_idx_v[0]), 64'd0);
    chk("t1_msb_first_data", 1, 64'(out_data1), 64'd0);
    chk("t1_msb_first_idx", 1, 64'(out_idx_v[1]), 64'd2);
    drain();

    // Element 1 a all ones.
    zero_fields();
    for (int i = 0; i < 3; i++) in_a_v[i] = {10'h3FF, 10'h000};
    in_valid_v = 3'b111;
    step();
    in_valid_v = '0;
    chk("t2_lsb_first_data", 0, 64'(out_data0), 64'd0);
    chk("t2_msb_first_data", 1, 64'(out_data1), 64'h3FF_0000_0000);
    chk("t2_msb_first_idx", 1, 64'(out_idx_v[1]), 64'd2);
    drain();

    // All fields all ones; the 32-bit packer pads two zero bits on beat 3.
    for (int i = 0; i < 3; i++) begin
      in_a_v[i] = '1; in_bar_c_v[i] = '1; in_bar_d_v[i] = '1; in_b_v[i] = '1;
    end
    in_valid_v = 3'b111;
    step();
    in_valid_v = '0;
    chk("t3_w32_first_data", 2, 64'(out_data2), 64'hFFFF_FFFF);
    drain();

    // Backpressure on beat 1 for five cycles.
    rand_fields(0);
    in_valid_v  = 3'b001;
    out_ready_v = 3'b001;
    step();
    in_valid_v = '0;
    step();
    out_ready_v = '0;
    repeat (5) step();
    chk("bp_held_idx", 0, 64'(out_idx_v[0]), 64'd1);
    drain();

    // Back-to-back: two vectors, continuous ready -> six busy cycles.
    busy = '{0, 0, 0};
    run(2, 0, 0, 1'b0, 40);
    chk("b2b_busy_cycles", 0, 64'(busy[0]), 64'd6);

    // Reset mid-vector, after beat 0 has been taken.
    for (int i = 0; i < 3; i++) rand_fields(i);
    in_valid_v  = 3'b111;
    out_ready_v = 3'b111;
    step();
    in_valid_v = '0;
    step();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_out_valid", i, 64'(out_valid_v[i]), 64'd0);
      chk("midrst_in_ready", i, 64'(in_ready_v[i]), 64'd1);
      exp_q[i].delete();
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(1, 1, 1, 1'b0, 40);

    // Randomized traffic with random sink stalls.
    run(10, 10, 10, 1'b1, 3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
